// File: rtl/dmem_loader.sv
// dmem_loader: arbitrates the data-memory write port
// between the CPU and a valid/ready byte-stream loader.
module dmem_loader #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] ld_base,
   input  logic [WIDTH:0]   ld_len,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   input  logic             cpu_en,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_d_in,
   output logic             mem_en,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_d_in,
   output logic             cpu_stall,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] wr_addr;
   logic [WIDTH-1:0] wr_addr_nx;
   logic [WIDTH:0]   remaining;
   logic [WIDTH:0]   remaining_nx;

   // state, write pointer and byte countdown
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wr_addr   <= '0;
         remaining <= '0;
      end else begin
         state     <= state_nx;
         wr_addr   <= wr_addr_nx;
         remaining <= remaining_nx;
      end
   end

   // next state; a zero-length request skips LOAD
   always_comb begin
      state_nx     = state;
      wr_addr_nx   = wr_addr;
      remaining_nx = remaining;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (ld_len != '0) begin
                  wr_addr_nx   = ld_base;
                  remaining_nx = ld_len;
                  state_nx     = S_LOAD;
               end else begin
                  state_nx = S_DONE;
               end
            end
         end
         S_LOAD: begin
            if (s_valid) begin
               wr_addr_nx   = wr_addr + 1'b1;
               remaining_nx = remaining - ONE;
               if (remaining == ONE)
                  state_nx = S_DONE;
            end
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // port mux; CPU keeps the address in DONE so reads stay valid
   always_comb begin
      s_ready  = 1'b0;
      mem_en   = cpu_en;
      mem_addr = cpu_addr;
      mem_d_in = cpu_d_in;
      unique case (state)
         S_LOAD: begin
            s_ready  = 1'b1;
            mem_en   = s_valid;
            mem_addr = wr_addr;
            mem_d_in = s_data;
         end
         S_DONE: mem_en = 1'b0;
         default: ;
      endcase
   end

   assign done      = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign cpu_stall = busy;

endmodule

// File: doc/dmem_loader.md
# dmem_loader

Upstream write-port controller for the data memory. It arbitrates the memory's single address/write port between the CPU datapath and a byte-stream loader. On `start` it takes ownership of the port and stalls the CPU. It then writes `ld_len` bytes from a valid/ready stream into consecutive addresses from `ld_base`, pulses `done`, and hands the port back to the CPU.

## Interface
- WIDTH, 8, data and address width; memory depth is 2^WIDTH
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- ld_base  in  WIDTH  first write address, captured with `start`
- ld_len  in  WIDTH+1  byte count (0..2^WIDTH), captured with `start`
- s_valid  in  1  stream byte valid
- s_data  in  WIDTH  stream byte
- s_ready  out  1  loader accepts a byte this cycle
- cpu_en  in  1  CPU write enable
- cpu_addr  in  WIDTH  CPU address
- cpu_d_in  in  WIDTH  CPU write data
- mem_en  out  1  to data memory write enable
- mem_addr  out  WIDTH  to data memory address
- mem_d_in  out  WIDTH  to data memory write data
- cpu_stall  out  1  CPU must hold its PC and writes
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse, load complete

## Operation
- State machine: IDLE -> LOAD -> DONE -> IDLE.
- IDLE, `start`=1, `ld_len`>0: capture `ld_base` into wr_addr and `ld_len` into remaining count. Go to LOAD.
- IDLE, `start`=1, `ld_len`=0: go directly to DONE. No memory write occurs.
- LOAD behaviour:
  - `s_ready`=1.
  - Each cycle with `s_valid`=1 is a transfer: write `s_data` at wr_addr, wr_addr+1 mod 2^WIDTH, remaining-1.
  - The transfer that brings remaining to 0 moves the state to DONE.
  - `s_valid`=0 cycles are idle. No timeout.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- `start` is ignored outside IDLE.
- `s_ready`=0 outside LOAD. Stream bytes offered there are not consumed.
- Address wraps 2^WIDTH-1 -> 0 silently. `ld_len`=2^WIDTH writes every location once.
- Port mux, combinational:
  - In LOAD: mem_en = `s_valid`; mem_addr = wr_addr; mem_d_in = `s_data`.
  - In IDLE: mem_en = `cpu_en`; mem_addr = `cpu_addr`; mem_d_in = `cpu_d_in`.
  - In DONE: mem_en = 0; mem_addr = `cpu_addr`; mem_d_in = `cpu_d_in`. This keeps CPU reads valid.
- cpu_stall = busy = (state != IDLE). `cpu_en` is dropped, not queued, while stalled.

## Timing
- Reset values: state IDLE, wr_addr 0, remaining 0, `done` 0, `busy` 0, `cpu_stall` 0, `s_ready` 0. Mem outputs follow the CPU inputs.
- Reset mid-load: immediate return to IDLE. Bytes already written stay in memory, because the memory is not cleared.
- Load latency:
  - `start` sampled at edge T. LOAD and `s_ready` hold from T+1.
  - With continuous `s_valid`, writes land on edges T+1 .. T+N.
  - `done` is high from T+N to T+N+1. IDLE from T+N+1.
- Zero-length load: `done` high from T to T+1. No write.
- `done`, `busy` and `cpu_stall` decode directly from the state register. They are glitch-free and have no extra latency.
- Memory write timing is unchanged: the data memory writes on the same edge that samples the transfer.

## Test plan
- Reset mid-load:
  - Stimulus: assert `rst` after 2 of 5 bytes.
  - Required: outputs return to reset values asynchronously; `done` never pulses.
  - Then: `start` again with base 0x20, len 1, byte 0x55. MEM[0x20]=0x55.
- Basic load:
  - Stimulus: base 0x10, len 4, bytes 0xA1..0xA4 back-to-back.
  - Required: MEM[0x10..0x13]=A1..A4. `done` pulses once, 5 cycles after `start`. `cpu_stall` is high for exactly 5 cycles.
- Gapped stream with wrap:
  - Stimulus: base 0xFE, len 3, `s_valid` toggling 1,0,1,0,1.
  - Required: MEM[0xFE]=b0, MEM[0xFF]=b1, MEM[0x00]=b2. Exactly 3 mem writes.
- CPU lockout:
  - Stimulus: `cpu_en`=1 to addr 0x11 with 0xEE during load.
  - Required: MEM[0x11] keeps the loader byte. After IDLE, the CPU write to 0x11 succeeds.
- Zero length and spurious start:
  - Stimulus: `ld_len`=0; separately, `start` pulsed mid-load.
  - Required: `done` the cycle after `start` with no mem_en. The mid-load `start` is ignored; base and count are unchanged.
